// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants, sprite geometry and the registered output bundle.
// Latency: n/a (declarations only).
// Backpressure: n/a; the raster free-runs.
package vga_pkg;

    // Horizontal timing in pixel clocks
    localparam int H_VISIBLE    = 640;
    localparam int H_FRONT      = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BACK       = 48;
    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

    // Vertical timing in lines
    localparam int V_VISIBLE    = 480;
    localparam int V_FRONT      = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BACK       = 33;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Sprite ROM geometry (both dimensions are powers of two)
    localparam int SPRITE_W      = 128;
    localparam int SPRITE_H      = 128;
    localparam int SPRITE_W_LOG2 = $clog2(SPRITE_W);
    localparam int SPRITE_H_LOG2 = $clog2(SPRITE_H);

    // Port / counter widths
    localparam int CNT_W      = 10;
    localparam int COL_W      = 10;
    localparam int ROW_W      = 9;
    localparam int ROM_ADDR_W = 14;

    // Everything the block drives, registered together so all outputs stay aligned
    typedef struct packed {
        logic [COL_W-1:0]      col;
        logic [ROW_W-1:0]      row;
        logic                  display_on;
        logic                  hsync;
        logic                  vsync;
        logic                  frame_start;
        logic                  sprite_hit;
        logic [ROM_ADDR_W-1:0] rom_addr;
    } scan_out_t;

    // Idle value: syncs are active-low, so they rest high
    function automatic scan_out_t scan_out_reset();
        scan_out_t v;
        v             = '0;
        v.hsync       = 1'b1;
        v.vsync       = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/vga_sprite_window.sv
// Sprite window: latches the sprite origin once per frame, tests the hit and forms the ROM address.
// Latency: combinational from counters; the origin latch updates at the start of vertical blanking.
// Backpressure: none; evaluated every pixel clock.
module vga_sprite_window
    import vga_pkg::CNT_W, vga_pkg::COL_W, vga_pkg::ROW_W, vga_pkg::ROM_ADDR_W;
#(
    parameter int V_VISIBLE = 480,
    parameter int SPRITE_W  = 128,
    parameter int SPRITE_H  = 128
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic [COL_W-1:0]      i_sprite_c,
    input  logic [ROW_W-1:0]      i_sprite_r,
    input  logic [CNT_W-1:0]      i_h_cnt,
    input  logic [CNT_W-1:0]      i_v_cnt,
    input  logic                  i_visible,
    output logic                  o_hit,
    output logic [ROM_ADDR_W-1:0] o_rom_addr
);

    localparam int SW_LOG2 = $clog2(SPRITE_W);
    localparam int SH_LOG2 = $clog2(SPRITE_H);

    logic [COL_W-1:0]   r_c;
    logic [ROW_W-1:0]   r_r;
    logic               w_latch;
    logic [10:0]        w_h_ext;
    logic [10:0]        w_v_ext;
    logic [10:0]        w_c_lo;
    logic [10:0]        w_c_hi;
    logic [10:0]        w_r_lo;
    logic [10:0]        w_r_hi;
    logic [SW_LOG2-1:0] w_dh;
    logic [SH_LOG2-1:0] w_dv;

    // First blanking line: the whole visible frame that follows sees one stable origin
    assign w_latch = (i_h_cnt == '0) && (i_v_cnt == CNT_W'(V_VISIBLE));

    // Hold the sprite origin for a full frame so the sprite cannot tear
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_c <= '0;
            r_r <= '0;
        end else if (w_latch) begin
            r_c <= i_sprite_c;
            r_r <= i_sprite_r;
        end
    end

    // 11-bit window bounds: origin + size - 1 never wraps, so off-screen parts just clip
    assign w_h_ext = {1'b0, i_h_cnt};
    assign w_v_ext = {1'b0, i_v_cnt};
    assign w_c_lo  = {1'b0, r_c};
    assign w_c_hi  = w_c_lo + 11'(SPRITE_W - 1);
    assign w_r_lo  = {2'b0, r_r};
    assign w_r_hi  = w_r_lo + 11'(SPRITE_H - 1);

    // Offsets inside the sprite; only the low bits matter because the window is a power of two
    assign w_dh = i_h_cnt[SW_LOG2-1:0] - r_c[SW_LOG2-1:0];
    assign w_dv = i_v_cnt[SH_LOG2-1:0] - r_r[SH_LOG2-1:0];

    // Hit test and row-major ROM address; address parks at 0 outside the window
    always_comb begin
        o_hit      = i_visible
                   && (w_h_ext >= w_c_lo) && (w_h_ext <= w_c_hi)
                   && (w_v_ext >= w_r_lo) && (w_v_ext <= w_r_hi);
        o_rom_addr = o_hit ? ROM_ADDR_W'({w_dv, w_dh}) : '0;
    end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster generator: h/v counters, visible area, active-low syncs, frame pulse, sprite window.
// Latency: every output is registered, 1 clock behind the counters, all mutually aligned.
// Backpressure: none; free-runs with a fixed H_TOTAL*V_TOTAL frame period.
module vga_scan_gen
    import vga_pkg::CNT_W, vga_pkg::COL_W, vga_pkg::ROW_W, vga_pkg::ROM_ADDR_W,
           vga_pkg::scan_out_t, vga_pkg::scan_out_reset;
#(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_pkg::H_FRONT,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BACK    = vga_pkg::H_BACK,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK,
    parameter int SPRITE_W  = vga_pkg::SPRITE_W,
    parameter int SPRITE_H  = vga_pkg::SPRITE_H
) (
    input  logic                  vga_clk,
    input  logic                  arst,
    input  logic [COL_W-1:0]      sprite_c,
    input  logic [ROW_W-1:0]      sprite_r,
    output logic [COL_W-1:0]      col,
    output logic [ROW_W-1:0]      row,
    output logic                  display_on,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_start,
    output logic                  sprite_hit,
    output logic [ROM_ADDR_W-1:0] rom_addr
);

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    logic [CNT_W-1:0]      r_h_cnt;
    logic [CNT_W-1:0]      r_v_cnt;
    logic                  w_h_last;
    logic                  w_v_last;
    logic                  w_visible;
    logic                  w_hit;
    logic [ROM_ADDR_W-1:0] w_rom_addr;
    scan_out_t             w_next;
    scan_out_t             r_out;

    assign w_h_last  = (r_h_cnt == CNT_W'(H_TOTAL - 1));
    assign w_v_last  = (r_v_cnt == CNT_W'(V_TOTAL - 1));
    assign w_visible = (r_h_cnt < CNT_W'(H_VISIBLE)) && (r_v_cnt < CNT_W'(V_VISIBLE));

    // Raster position: h wraps every line, v advances on the h wrap and wraps per frame
    always_ff @(posedge vga_clk or posedge arst) begin
        if (arst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + CNT_W'(1);
        end
    end

    vga_sprite_window #(
        .V_VISIBLE (V_VISIBLE),
        .SPRITE_W  (SPRITE_W),
        .SPRITE_H  (SPRITE_H)
    ) u_sprite (
        .i_clk      (vga_clk),
        .i_arst     (arst),
        .i_sprite_c (sprite_c),
        .i_sprite_r (sprite_r),
        .i_h_cnt    (r_h_cnt),
        .i_v_cnt    (r_v_cnt),
        .i_visible  (w_visible),
        .o_hit      (w_hit),
        .o_rom_addr (w_rom_addr)
    );

    // Decode the current counter state into the next output bundle
    always_comb begin
        w_next             = scan_out_reset();
        w_next.col         = w_visible ? r_h_cnt : '0;
        w_next.row         = w_visible ? r_v_cnt[ROW_W-1:0] : '0;
        w_next.display_on  = w_visible;
        w_next.hsync       = !((r_h_cnt >= CNT_W'(H_SYNC_START)) && (r_h_cnt < CNT_W'(H_SYNC_END)));
        w_next.vsync       = !((r_v_cnt >= CNT_W'(V_SYNC_START)) && (r_v_cnt < CNT_W'(V_SYNC_END)));
        w_next.frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
        w_next.sprite_hit  = w_hit;
        w_next.rom_addr    = w_rom_addr;
    end

    // Single register stage keeps every output (and the ROM address) on the same clock
    always_ff @(posedge vga_clk or posedge arst) begin
        if (arst) begin
            r_out <= scan_out_reset();
        end else begin
            r_out <= w_next;
        end
    end

    assign col         = r_out.col;
    assign row         = r_out.row;
    assign display_on  = r_out.display_on;
    assign hsync       = r_out.hsync;
    assign vsync       = r_out.vsync;
    assign frame_start = r_out.frame_start;
    assign sprite_hit  = r_out.sprite_hit;
    assign rom_addr    = r_out.rom_addr;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench: full-size raster (first lines) plus a scaled raster (whole frames) against an arithmetic model.
module tb_vga_scan_gen;

    // Scaled timing so whole frames, the sprite latch and clipping fit a short run
    localparam int S_HV = 64, S_HF = 4, S_HS = 8, S_HB = 4;
    localparam int S_VV = 48, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_SW = 16, S_SH = 16;
    localparam int S_FRAME = (S_HV + S_HF + S_HS + S_HB) * (S_VV + S_VF + S_VS + S_VB);
    localparam int MAX_FAIL = 20;

    logic        vga_clk = 1'b0;
    logic        arst;
    logic [9:0]  f_c_in, s_c_in;
    logic [8:0]  f_r_in, s_r_in;

    logic [9:0]  f_col, s_col;
    logic [8:0]  f_row, s_row;
    logic        f_disp, f_hs, f_vs, f_fs, f_hit;
    logic        s_disp, s_hs, s_vs, s_fs, s_hit;
    logic [13:0] f_addr, s_addr;
    logic [37:0] f_vec, s_vec;
    logic [37:0] rst_vec;

    int n_assert = 0;
    int n_fail   = 0;
    int t;
    int f_lc, f_lr, s_lc, s_lr;
    int last_fs_t;
    int vis_cnt;

    always #20 vga_clk = ~vga_clk;

    vga_scan_gen u_full (
        .vga_clk(vga_clk), .arst(arst), .sprite_c(f_c_in), .sprite_r(f_r_in),
        .col(f_col), .row(f_row), .display_on(f_disp), .hsync(f_hs), .vsync(f_vs),
        .frame_start(f_fs), .sprite_hit(f_hit), .rom_addr(f_addr)
    );

    vga_scan_gen #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .SPRITE_W(S_SW), .SPRITE_H(S_SH)
    ) u_small (
        .vga_clk(vga_clk), .arst(arst), .sprite_c(s_c_in), .sprite_r(s_r_in),
        .col(s_col), .row(s_row), .display_on(s_disp), .hsync(s_hs), .vsync(s_vs),
        .frame_start(s_fs), .sprite_hit(s_hit), .rom_addr(s_addr)
    );

    assign f_vec   = {f_col, f_row, f_disp, f_hs, f_vs, f_fs, f_hit, f_addr};
    assign s_vec   = {s_col, s_row, s_disp, s_hs, s_vs, s_fs, s_hit, s_addr};
    assign rst_vec = {10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'd0};

    // Expected outputs for raster position p (clocks since frame start), from the timing rules
    function automatic logic [37:0] model(int hv, int hf, int hs, int hb, int vv, int vf, int vs,
                                          int vb, int sw, int sh, int p, int c, int r);
        int htot, vtot, h, v, addr;
        logic vis, hit, hsn, vsn, fs;
        htot = hv + hf + hs + hb;
        vtot = vv + vf + vs + vb;
        h    = p % htot;
        v    = (p / htot) % vtot;
        vis  = (h < hv) && (v < vv);
        hsn  = !((h >= hv + hf) && (h < hv + hf + hs));
        vsn  = !((v >= vv + vf) && (v < vv + vf + vs));
        fs   = (h == 0) && (v == 0);
        hit  = vis && (h >= c) && (h < c + sw) && (v >= r) && (v < r + sh);
        addr = hit ? (v - r) * sw + (h - c) : 0;
        return {10'(vis ? h : 0), 9'(vis ? v : 0), vis, hsn, vsn, fs, hit, 14'(addr)};
    endfunction

    function automatic logic [37:0] exp_full(int p, int c, int r);
        return model(vga_pkg::H_VISIBLE, vga_pkg::H_FRONT, vga_pkg::H_SYNC, vga_pkg::H_BACK,
                     vga_pkg::V_VISIBLE, vga_pkg::V_FRONT, vga_pkg::V_SYNC, vga_pkg::V_BACK,
                     vga_pkg::SPRITE_W, vga_pkg::SPRITE_H, p, c, r);
    endfunction

    function automatic logic [37:0] exp_small(int p, int c, int r);
        return model(S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, S_SW, S_SH, p, c, r);
    endfunction

    task automatic check_vec(input string tag, input logic [37:0] act, input logic [37:0] exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, act, exp);
        end
    endtask

    task automatic check_int(input string tag, input int act, input int exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, act, exp);
        end
    endtask

    task automatic new_small_pos();
        s_c_in = 10'($urandom_range(0, 80));
        s_r_in = 9'($urandom_range(0, 60));
    endtask

    task automatic model_restart();
        t = 0; f_lc = 0; f_lr = 0; s_lc = 0; s_lr = 0;
        last_fs_t = -1; vis_cnt = 0;
    endtask

    // One output cycle: compare both DUTs, track the sprite latch, then maybe move the sprite
    task automatic step();
        int sh, sv, fh, fv;
        @(posedge vga_clk);
        @(negedge vga_clk);
        check_vec("full_raster", f_vec, exp_full(t, f_lc, f_lr));
        check_vec("small_raster", s_vec, exp_small(t, s_lc, s_lr));
        // frame-level bookkeeping on the scaled raster
        if (t % S_FRAME == 0 && t > 0) begin
            check_int("small_visible_per_frame", vis_cnt, S_HV * S_VV);
            vis_cnt = 0;
        end
        vis_cnt += int'(s_disp);
        if (s_fs) begin
            if (last_fs_t >= 0) check_int("small_frame_period", t - last_fs_t, S_FRAME);
            last_fs_t = t;
        end
        // the position held at the previous edge is what each DUT latched at (0, V_VISIBLE)
        fh = t % (vga_pkg::H_TOTAL);
        fv = (t / vga_pkg::H_TOTAL) % vga_pkg::V_TOTAL;
        if (fh == 0 && fv == vga_pkg::V_VISIBLE) begin f_lc = int'(f_c_in); f_lr = int'(f_r_in); end
        sh = t % (S_HV + S_HF + S_HS + S_HB);
        sv = (t / (S_HV + S_HF + S_HS + S_HB)) % (S_VV + S_VF + S_VS + S_VB);
        if (sh == 0 && sv == S_VV) begin s_lc = int'(s_c_in); s_lr = int'(s_r_in); end
        t++;
        if ($urandom_range(0, 499) == 0) new_small_pos();
        if ($urandom_range(0, 999) == 0) begin
            f_c_in = 10'($urandom_range(0, 1023));
            f_r_in = 9'($urandom_range(0, 511));
        end
    endtask

    initial begin
        // Reset state, held across a few edges
        arst   = 1'b1;
        f_c_in = 10'($urandom_range(0, 1023));
        f_r_in = 9'($urandom_range(0, 511));
        s_c_in = 10'd56;
        s_r_in = 9'd40;
        model_restart();
        #5;
        check_vec("full_reset", f_vec, rst_vec);
        check_vec("small_reset", s_vec, rst_vec);
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        check_vec("full_reset_held", f_vec, rst_vec);
        check_vec("small_reset_held", s_vec, rst_vec);
        arst = 1'b0;

        // Free run: full raster lines 0..25 with sprite at origin 0; scaled raster ~4.6 frames
        for (int i = 0; i < 20300 && n_fail < MAX_FAIL; i++) step();

        // Asynchronous reset mid-line (full raster at h=300, v=25): outputs clear before any edge
        arst = 1'b1;
        #1;
        check_vec("full_async_reset", f_vec, rst_vec);
        check_vec("small_async_reset", s_vec, rst_vec);
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        check_vec("full_reset_after3", f_vec, rst_vec);
        check_vec("small_reset_after3", s_vec, rst_vec);
        // clipped sprite origin for the first post-reset latch
        s_c_in = 10'd56;
        s_r_in = 9'd40;
        model_restart();
        arst = 1'b0;

        // Post-reset run: frame period measured from the first post-reset output cycle
        for (int i = 0; i < 14000 && n_fail < MAX_FAIL; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
